uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit controller that sequences the UART-Tx PISO frame register (PisoReg). It arbitrates two byte requesters round-robin into a small FIFO. For each byte it latches the line configuration, builds the 11-bit frame including parity, and drives the PISO send/FrameOut/config inputs. It then watches tx_active/tx_done to pace frames back to back, and detects a PISO that never starts.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
TIMEOUT, 16, BaudOut cycles allowed between send assertion and tx_active high

Ports:
BaudOut  in  1  baud-rate clock; all state on rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  2  requester i has a byte
req_data0  in  8  requester 0 byte
req_data1  in  8  requester 1 byte
req_ready  out  2  byte from requester i accepted this cycle
cfg_stop_bits  in  1  0 = 1 stop bit, 1 = 2 stop bits
cfg_data_length  in  1  1 = 8 data bits, 0 = 7 data bits
cfg_parity_type  in  2  00 none, 01 odd, 10 even, 11 none
send  out  1  to PISO send
FrameOut  out  11  to PISO FrameOut
stop_bits  out  1  latched config to PISO
data_length  out  1  latched config to PISO
parity_type  out  2  latched config to PISO
tx_active  in  1  from PISO
tx_done  in  1  from PISO
busy  out  1  FSM not IDLE or FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
tx_err  out  1  one-cycle pulse on start timeout

Behaviour:
- Reset (rst=0, async): FIFO empty, rr pointer = 0, FSM IDLE, send=0, FrameOut=11'h7FF, stop_bits=0, data_length=1, parity_type=00, tx_err=0. req_ready is forced to 0 while rst=0. A reset mid-frame discards the FIFO and the current frame.
- Arbiter:
  - At most one push per cycle.
  - The granted requester is the valid one. If both are valid, the rr pointer chooses.
  - req_ready[i] = grant[i] & !full. It is combinational from the valid inputs and registered state.
  - rr pointer flips to the other requester after any push made while both were valid.
  - The non-granted requester must hold its valid and data.
- FIFO: push and pop in the same cycle are allowed when full or empty, with these rules:
  - When full, a pop frees the slot in the same cycle, so push is accepted.
  - When empty, there is no bypass. A pushed byte is poppable on the next cycle.
  - fifo_count is updated on the clock edge.
- FSM states:
  - IDLE: if FIFO not empty, pop the head and go to LOAD.
  - LOAD (1 cycle): latch the cfg_* inputs into stop_bits/data_length/parity_type, build FrameOut, clear the timeout counter, go to START.
  - START: send=1. If tx_active=1, go to WAIT. If the counter reaches TIMEOUT, pulse tx_err, drop send, go to GAP (the byte is dropped).
  - WAIT: send=0. When tx_done=1, go to GAP.
  - GAP (1 cycle): go to IDLE. This gives a minimum 1-cycle idle between frames.
- Config and FrameOut hold stable from LOAD until the next LOAD. cfg_* changes at any other time do not affect the frame in flight.
- Frame build, with N = 8 if data_length else 7:
  - bit0 = 0 (start bit).
  - bits[N:1] = data[N-1:0]. In 7-bit mode data[7] is ignored.
  - bit N+1 = parity if parity is enabled. Parity is p = ^data[N-1:0] for even and ~^data[N-1:0] for odd.
  - All remaining upper bits = 1 (stop bits and idle).
- tx_done seen outside WAIT is ignored.
- Latency: a byte pushed at cycle t into an empty FIFO with the FSM in IDLE gives IDLE pop at t+1, LOAD at t+2, and send=1 at t+3.

Decomposition:
- Shared package holds:
  - Parity encodings PAR_NONE0=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE1=2'b11.
  - FSM state encodings.
  - FRAME_W=11 and IDLE_FRAME=11'h7FF.
- Sub-module uart_tx_fifo: synchronous FIFO parameterised by DEPTH with full/empty/count. It is reused by a later Rx path.
- Arbiter and frame build stay inline.

Test Plan:
- Byte 8'hA5, 8-bit, even parity, cfg 4'b0110 → FrameOut=11'h54A. send high until tx_active, then low. After tx_done: GAP, then IDLE.
- Same byte, odd parity (01) → FrameOut=11'h74A. Byte 8'h3C, no parity (00 and 11) → FrameOut=11'h678 in both cases.
- 7-bit, 2 stop bits, odd parity (cfg 4'b1001), byte 8'hB5 → FrameOut=11'h76A (data[7] ignored).
- Both requesters valid continuously with 0x11/0x22 and a PISO model answering → grants alternate 0,1,0,1. At count=DEPTH, req_ready=00 until a pop, and push is accepted in the pop cycle. Bytes are transmitted in FIFO order.
- tx_active held 0 → after TIMEOUT=16 cycles in START: tx_err pulses for 1 cycle, send drops, next byte proceeds.
- rst pulled low during WAIT → immediately send=0, FrameOut=11'h7FF, fifo_count=0, req_ready=00. After release: idle until a new request arrives.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path.
//   - Parity-type encodings as they appear on cfg_parity_type / parity_type.
//   - Transmit FSM state encoding.
//   - Frame width, idle (all-ones) frame, and the frame builder used at LOAD.
package uart_tx_ctrl_pkg;

    localparam int                 FRAME_W    = 11;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE1 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } txState_t;

    // Start bit at bit 0, data LSB first, optional parity right after the
    // last data bit; everything above is left at 1 (stop bits and line idle).
    function automatic logic [FRAME_W-1:0] buildFrame(
        input logic [7:0] data,
        input logic       dataLength,
        input logic [1:0] parityType
    );
        logic [FRAME_W-1:0] frame;
        logic               par;
        frame    = IDLE_FRAME;
        frame[0] = 1'b0;
        if (dataLength) begin
            frame[8:1] = data;
            par        = ^data;
        end else begin
            frame[7:1] = data[6:0];
            par        = ^data[6:0];
        end
        if (parityType == PAR_ODD) par = ~par;
        if (parityType == PAR_ODD || parityType == PAR_EVEN) begin
            if (dataLength) frame[9] = par;
            else            frame[8] = par;
        end
        return frame;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk, rst_n     : clock, asynchronous active-low reset (clears pointers)
//   push, pushData : write request; honoured when not full, or when full and
//                    a pop happens in the same cycle
//   pop, popData   : read request; popData is the current head (no bypass,
//                    so a byte written this cycle is readable next cycle)
//   full, empty    : status
//   count          : occupancy, 0..DEPTH
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr;
    logic             doPush, doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wrPtr - rdPtr;
    assign empty   = (wrPtr == rdPtr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign popData = mem[rdPtr[AW-1:0]];

    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller driving the PISO frame register.
//   BaudOut, rst          : baud clock, asynchronous active-low reset
//   req_valid/req_ready   : two byte requesters, round-robin arbitrated
//   req_data0/req_data1   : requester bytes
//   cfg_*                 : live line configuration, sampled once per frame
//   send, FrameOut        : PISO start strobe and 11-bit frame
//   stop_bits/data_length/parity_type : configuration held for the PISO
//   tx_active, tx_done    : PISO status
//   busy, fifo_count      : activity and queue occupancy
//   tx_err                : one-cycle pulse when the PISO never starts
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   BaudOut,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [7:0]             req_data0,
    input  logic [7:0]             req_data1,
    output logic [1:0]             req_ready,
    input  logic                   cfg_stop_bits,
    input  logic                   cfg_data_length,
    input  logic [1:0]             cfg_parity_type,
    output logic                   send,
    output logic [FRAME_W-1:0]     FrameOut,
    output logic                   stop_bits,
    output logic                   data_length,
    output logic [1:0]             parity_type,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   tx_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    txState_t     state, stateNext;
    logic         rrPtr;
    logic [1:0]   grant;
    logic         fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [7:0]   pushData, headData, dataReg;
    logic [TW-1:0] toCnt;
    logic         errNext;

    // ---------------- arbiter ----------------
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rrPtr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pop depends only on registered state, so letting it open a slot in a
    // full FIFO the same cycle creates no combinational loop.
    assign fifoPop   = (state == S_IDLE) & ~fifoEmpty;
    assign req_ready = rst ? (grant & {2{~fifoFull | fifoPop}}) : 2'b00;
    assign fifoPush  = |req_ready;
    assign pushData  = grant[1] ? req_data1 : req_data0;

    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst)                          rrPtr <= 1'b0;
        else if (fifoPush && &req_valid)   rrPtr <= ~rrPtr;
    end

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) uFifo (
        .clk      (BaudOut),
        .rst_n    (rst),
        .push     (fifoPush),
        .pushData (pushData),
        .pop      (fifoPop),
        .popData  (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifo_count)
    );

    // ---------------- FSM ----------------
    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        case (state)
            S_IDLE:  if (!fifoEmpty) stateNext = S_LOAD;
            S_LOAD:  stateNext = S_START;
            S_START: begin
                if (tx_active) begin
                    stateNext = S_WAIT;
                end else if (toCnt == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT full cycles in START without a start: drop byte.
                    stateNext = S_GAP;
                    errNext   = 1'b1;
                end
            end
            S_WAIT:  if (tx_done) stateNext = S_GAP;
            S_GAP:   stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            dataReg     <= 8'h00;
            toCnt       <= '0;
            tx_err      <= 1'b0;
            FrameOut    <= IDLE_FRAME;
            stop_bits   <= 1'b0;
            data_length <= 1'b1;
            parity_type <= PAR_NONE0;
        end else begin
            state  <= stateNext;
            tx_err <= errNext;
            if (fifoPop) dataReg <= headData;
            if (state == S_LOAD) begin
                stop_bits   <= cfg_stop_bits;
                data_length <= cfg_data_length;
                parity_type <= cfg_parity_type;
                FrameOut    <= buildFrame(dataReg, cfg_data_length, cfg_parity_type);
                toCnt       <= '0;
            end else if (state == S_START) begin
                toCnt <= toCnt + 1'b1;
            end
        end
    end

    assign send = (state == S_START);
    assign busy = (state != S_IDLE) | ~fifoEmpty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: accepted bytes push their expected frame,
// a monitor compares each frame as send rises; a small PISO model answers.
module tb_uart_tx_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        BaudOut = 1'b0;
    logic        rst;
    logic [1:0]  req_valid = 2'b00;
    logic [7:0]  req_data0 = 8'h00, req_data1 = 8'h00;
    logic [1:0]  req_ready;
    logic        cfg_stop_bits = 1'b0, cfg_data_length = 1'b1;
    logic [1:0]  cfg_parity_type = 2'b00;
    logic        send;
    logic [10:0] FrameOut;
    logic        stop_bits, data_length;
    logic [1:0]  parity_type;
    logic        tx_active = 1'b0, tx_done = 1'b0;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        tx_err;

    uart_tx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .BaudOut(BaudOut), .rst(rst), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .cfg_stop_bits(cfg_stop_bits), .cfg_data_length(cfg_data_length),
        .cfg_parity_type(cfg_parity_type), .send(send), .FrameOut(FrameOut),
        .stop_bits(stop_bits), .data_length(data_length), .parity_type(parity_type),
        .tx_active(tx_active), .tx_done(tx_done), .busy(busy),
        .fifo_count(fifo_count), .tx_err(tx_err)
    );

    always #5 BaudOut = ~BaudOut;

    typedef struct {
        logic [10:0] frame;
        logic        sb;
        logic        dl;
        logic [1:0]  pt;
    } exp_t;

    exp_t sbq[$];
    exp_t monE;
    int   vecs = 0, errs = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame from the line rules: start 0, N data bits LSB first, parity bit
    // making the ones count even (even) or odd (odd), rest ones.
    function automatic logic [10:0] model(logic [7:0] d, logic dl, logic [1:0] pt);
        int n = dl ? 8 : 7;
        int ones = 0;
        logic [10:0] f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        if (pt == 2'b10)      f[n+1] = (ones % 2 == 1);
        else if (pt == 2'b01) f[n+1] = (ones % 2 == 0);
        return f;
    endfunction

    // ---------------- PISO model ----------------
    int pState = 0, pDelay = 0, pLen = 0;
    bit pisoEn = 1, holdDone = 0, pisoKill = 0;
    always @(negedge BaudOut) begin
        if (pisoKill) begin
            tx_active = 1'b0; tx_done = 1'b0; pState = 0;
        end else begin
            case (pState)
                0: begin
                    tx_done = 1'b0;
                    if (send && pisoEn) begin
                        pDelay = $urandom_range(0, 3);
                        if (pDelay == 0) begin
                            tx_active = 1'b1; pLen = $urandom_range(1, 4); pState = 2;
                        end else pState = 1;
                    end
                end
                1: begin
                    pDelay--;
                    if (pDelay == 0) begin
                        tx_active = 1'b1; pLen = $urandom_range(1, 4); pState = 2;
                    end
                end
                default: if (!holdDone) begin
                    if (pLen == 0) begin
                        tx_active = 1'b0; tx_done = 1'b1; pState = 0;
                    end else pLen--;
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic prevSend = 1'b0;
    int   sendRun = 0, errPulses = 0, frames = 0;
    bit   expTimeout = 0;
    time  sendRiseTime = 0, acceptTime = 0;
    always @(negedge BaudOut) begin
        if (!rst) begin
            prevSend = 1'b0; sendRun = 0;
        end else begin
            if (tx_err) errPulses++;
            if (send && !prevSend) begin
                sendRiseTime = $time;
                if (sbq.size() == 0) chk("unexpected_frame", 32'(FrameOut), 32'h0);
                else begin
                    monE = sbq.pop_front();
                    chk("FrameOut", 32'(FrameOut), 32'(monE.frame));
                    chk("cfg_latched", 32'({stop_bits, data_length, parity_type}),
                        32'({monE.sb, monE.dl, monE.pt}));
                    frames++;
                end
            end
            if (send) sendRun++;
            else if (prevSend) begin
                if (expTimeout) begin
                    chk("timeout_len", 32'(sendRun), 32'(TIMEOUT));
                    chk("tx_err_at_drop", 32'(tx_err), 32'd1);
                end else chk("tx_err_quiet", 32'(tx_err), 32'd0);
                sendRun = 0;
            end
            prevSend = send;
        end
    end

    // ---------------- stimulus ----------------
    bit rrModel = 0;
    int fullStall = 0, fullPush = 0;

    // mode 0: random bytes, mode 1: fixed 0x11/0x22, mode 2: 'given' on
    // requester 0 with literal expected frame 'lit'.
    task automatic drive(int nBytes, int mode, int pct, int budget,
                         logic [7:0] given, logic [10:0] lit);
        logic [1:0] v = 2'b00;
        logic [7:0] d[2];
        int issued = 0, acc = 0, cyc = 0;
        bit expectFull = 0;
        exp_t e;
        d[0] = 8'h00; d[1] = 8'h00;
        while (acc < nBytes && cyc < budget) begin
            @(negedge BaudOut); cyc++;
            if (expectFull) begin
                chk("push_on_full_count", 32'(fifo_count), 32'(DEPTH));
                expectFull = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && issued < nBytes && !(mode == 2 && i == 1) &&
                    $urandom_range(99) < pct) begin
                    v[i] = 1'b1;
                    d[i] = (mode == 1) ? (i == 1 ? 8'h22 : 8'h11) :
                           (mode == 2) ? given : 8'($urandom);
                    issued++;
                end
            end
            req_valid = v; req_data0 = d[0]; req_data1 = d[1];
            #1;
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("ready_needs_valid", 32'(req_ready & ~v), 32'd0);
            if (fifo_count == 3'(DEPTH)) begin
                if (req_ready != 2'b00) begin fullPush++; expectFull = 1; end
                else fullStall++;
            end
            if (v == 2'b11 && req_ready != 2'b00) begin
                chk("rr_grant", 32'(req_ready), rrModel ? 32'd2 : 32'd1);
                rrModel = ~rrModel;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i] && v[i]) begin
                    e.frame = (mode == 2) ? lit : model(d[i], cfg_data_length, cfg_parity_type);
                    e.sb = cfg_stop_bits; e.dl = cfg_data_length; e.pt = cfg_parity_type;
                    sbq.push_back(e);
                    v[i] = 1'b0; acc++;
                    acceptTime = $time;
                end
            end
        end
        if (acc < nBytes) chk("drive_budget", 32'(acc), 32'(nBytes));
        @(negedge BaudOut);
        req_valid = 2'b00;
    endtask

    task automatic waitIdle(int budget);
        int c = 0;
        do begin
            @(negedge BaudOut); #2; c++;
        end while (!(busy == 1'b0 && sbq.size() == 0 && pState == 0) && c < budget);
        chk("idle_reached", 32'(busy == 1'b0 && sbq.size() == 0), 32'd1);
    endtask

    task automatic directed(logic [7:0] b, logic [3:0] cfg, logic [10:0] lit);
        int f0, c;
        {cfg_stop_bits, cfg_data_length, cfg_parity_type} = cfg;
        f0 = frames;
        drive(1, 2, 100, 20, b, lit);
        c = 0;
        while (frames == f0 && c < 20) begin @(negedge BaudOut); #2; c++; end
        chk("latency", 32'((sendRiseTime - acceptTime + 1) / 10), 32'd3);
        c = 0;
        do begin @(negedge BaudOut); #2; c++; end while (!tx_done && c < 40);
        @(negedge BaudOut); #1;
        chk("gap_busy", 32'(busy), 32'd1);
        @(negedge BaudOut); #1;
        chk("idle_after_gap", 32'(busy), 32'd0);
        waitIdle(50);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge BaudOut);
        req_valid = 2'b11;
        #1;
        chk("rst_send", 32'(send), 32'd0);
        chk("rst_frame", 32'(FrameOut), 32'h7FF);
        chk("rst_cfg", 32'({stop_bits, data_length, parity_type}), 32'b0100);
        chk("rst_err", 32'(tx_err), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge BaudOut);
        req_valid = 2'b00; rst = 1'b1;

        directed(8'hA5, 4'b0110, 11'h54A);
        directed(8'hA5, 4'b0101, 11'h74A);
        directed(8'h3C, 4'b0100, 11'h678);
        directed(8'h3C, 4'b0111, 11'h678);
        directed(8'hB5, 4'b1001, 11'h76A);

        for (int b = 0; b < 4; b++) begin
            {cfg_stop_bits, cfg_data_length, cfg_parity_type} = 4'($urandom);
            drive(10, 0, 60, 2000, 8'h00, 11'h0);
            waitIdle(2000);
        end

        {cfg_stop_bits, cfg_data_length, cfg_parity_type} = 4'b0110;
        fullStall = 0; fullPush = 0;
        drive(12, 1, 100, 3000, 8'h00, 11'h0);
        waitIdle(2000);
        chk("full_stall_seen", 32'(fullStall > 0), 32'd1);
        chk("push_on_pop_seen", 32'(fullPush > 0), 32'd1);

        pisoEn = 0; expTimeout = 1; errPulses = 0;
        drive(2, 0, 100, 200, 8'h00, 11'h0);
        waitIdle(200);
        chk("timeout_err_pulses", 32'(errPulses), 32'd2);
        expTimeout = 0; pisoEn = 1;
        drive(1, 0, 100, 50, 8'h00, 11'h0);
        waitIdle(100);

        {cfg_stop_bits, cfg_data_length, cfg_parity_type} = 4'b1001;
        holdDone = 1;
        drive(1, 0, 100, 50, 8'h00, 11'h0);
        c = 0;
        do begin @(negedge BaudOut); #2; c++; end
        while (!(pState == 2 && !send && tx_active) && c < 40);
        chk("reached_wait", 32'(pState == 2 && !send), 32'd1);
        drive(2, 0, 100, 50, 8'h00, 11'h0);
        @(negedge BaudOut);
        rst = 1'b0; req_valid = 2'b11;
        #1;
        chk("mid_rst_send", 32'(send), 32'd0);
        chk("mid_rst_frame", 32'(FrameOut), 32'h7FF);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_cfg", 32'({stop_bits, data_length, parity_type}), 32'b0100);
        sbq.delete();
        pisoKill = 1; holdDone = 0;
        repeat (2) @(negedge BaudOut);
        rst = 1'b1; req_valid = 2'b00; pisoKill = 0; rrModel = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge BaudOut); #1;
            chk("idle_after_reset", 32'({send, busy}), 32'd0);
        end
        drive(1, 0, 100, 50, 8'h00, 11'h0);
        waitIdle(100);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
